// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA constants and fetch-state encoding
package isa_pkg;

    localparam int INSTR_W = 32;
    localparam int OP_HI   = 31;
    localparam int OP_LO   = 28;

    localparam logic [OP_HI-OP_LO:0] OP_HLT = 4'hF;
    localparam logic [OP_HI-OP_LO:0] OP_BRA = 4'h1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetchState_t;

    function automatic logic isHalt(input logic [INSTR_W-1:0] instr);
        return instr[OP_HI:OP_LO] == OP_HLT;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with req/ack memory port and branch redirect
module instr_fetch
    import isa_pkg::*;
#(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               iClk,
    input  logic               iRst_n,
    output logic               oImemReq,
    output logic [ADDR_W-1:0]  oImemAddr,
    input  logic               iImemAck,
    input  logic [INSTR_W-1:0] iImemData,
    output logic [INSTR_W-1:0] oInstruction,
    output logic [ADDR_W-1:0]  oPc,
    output logic               oValid,
    input  logic               iReady,
    input  logic               iBranchTaken,
    input  logic [ADDR_W-1:0]  iBranchTarget,
    output logic               oHalted
);

    fetchState_t       state;
    logic [ADDR_W-1:0] pc;
    logic              discard;

    // Fetch FSM: one instruction in flight, branch redirect wins over every other event.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            discard      <= 1'b0;
            oImemReq     <= 1'b0;
            oImemAddr    <= RESET_PC;
            oInstruction <= '0;
            oPc          <= RESET_PC;
            oValid       <= 1'b0;
            oHalted      <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (iBranchTaken) begin
                        pc <= iBranchTarget;
                    end else begin
                        oImemReq  <= 1'b1;
                        oImemAddr <= pc;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (iImemAck) begin
                        // The handshake always completes; redirects only decide the data's fate.
                        oImemReq <= 1'b0;
                        if (iBranchTaken) begin
                            pc      <= iBranchTarget;
                            discard <= 1'b0;
                            state   <= FETCH;
                        end else if (discard) begin
                            discard <= 1'b0;
                            state   <= FETCH;
                        end else begin
                            oInstruction <= iImemData;
                            oPc          <= pc;
                            pc           <= pc + ADDR_W'(1);
                            oValid       <= 1'b1;
                            state        <= HOLD;
                        end
                    end else if (iBranchTaken) begin
                        pc      <= iBranchTarget;
                        discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (iBranchTaken) begin
                        pc     <= iBranchTarget;
                        oValid <= 1'b0;
                        state  <= FETCH;
                    end else if (iReady) begin
                        oValid <= 1'b0;
                        if (isHalt(oInstruction)) begin
                            oHalted <= 1'b1;
                            state   <= HALT;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    if (iBranchTaken) begin
                        pc      <= iBranchTarget;
                        oHalted <= 1'b0;
                        state   <= FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req, ack = 1'b0;
    logic [11:0] addr;
    logic [31:0] data = 32'h0;
    logic [31:0] instr;
    logic [11:0] pc;
    logic        valid, halted;
    logic        ready = 1'b1;
    logic        br = 1'b0;
    logic [11:0] brTarget = 12'h0;

    logic        req2, ack2 = 1'b0;
    logic [11:0] addr2;
    logic [31:0] data2 = 32'h0;
    logic [31:0] instr2;
    logic [11:0] pc2;
    logic        valid2, halted2;
    logic        ready2 = 1'b1;
    logic        br2 = 1'b0;
    logic [11:0] brTarget2 = 12'h0;

    logic [31:0] mem [4096];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
        .iClk(clk), .iRst_n(rst_n),
        .oImemReq(req), .oImemAddr(addr), .iImemAck(ack), .iImemData(data),
        .oInstruction(instr), .oPc(pc), .oValid(valid), .iReady(ready),
        .iBranchTaken(br), .iBranchTarget(brTarget), .oHalted(halted)
    );

    instr_fetch #(.ADDR_W(12), .RESET_PC(12'hFFF)) dut2 (
        .iClk(clk), .iRst_n(rst_n),
        .oImemReq(req2), .oImemAddr(addr2), .iImemAck(ack2), .iImemData(data2),
        .oInstruction(instr2), .oPc(pc2), .oValid(valid2), .iReady(ready2),
        .iBranchTaken(br2), .iBranchTarget(brTarget2), .oHalted(halted2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 | 32'(i);
        mem[3] = 32'hF000_0000;
    end

    // memory responder for dut: ack ackDelay cycles after the request is first seen
    int ackDelay = 2;
    int cnt1 = 0;
    always @(negedge clk) begin
        ack  = 1'b0;
        data = $urandom;
        if (!rst_n || !req) begin
            cnt1 = 0;
        end else begin
            cnt1++;
            if (cnt1 >= ackDelay) begin
                ack  = 1'b1;
                data = mem[addr];
                cnt1 = 0;
            end
        end
    end

    // memory responder for dut2: fixed one-cycle latency
    always @(negedge clk) begin
        ack2  = rst_n && req2 && !ack2;
        data2 = ack2 ? mem[addr2] : 32'hDEAD_BEEF;
    end

    // architectural model and per-cycle compare for dut
    logic        prevReq = 1'b0, prevValid = 1'b0;
    logic [11:0] prevPcO = 12'h0;
    logic [31:0] prevInstrO = 32'h0;
    logic [11:0] modelPc = 12'h0, reqAddrM = 12'h0, expPc = 12'h0;
    logic [31:0] expInstr = 32'h0;
    logic        haveDel = 1'b0, expHalted = 1'b0, inflightDiscard = 1'b0;
    int          xferCount = 0, reqCount = 0;
    logic [11:0] delPc[$];
    logic [31:0] delInstr[$];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                chk("rst_req", 32'(req), 32'h0);
                chk("rst_valid", 32'(valid), 32'h0);
                chk("rst_halted", 32'(halted), 32'h0);
                chk("rst_pc", 32'(pc), 32'h0);
                modelPc = 12'h000; haveDel = 1'b0; expHalted = 1'b0; inflightDiscard = 1'b0;
                prevReq = 1'b0; prevValid = 1'b0;
            end else begin
                if (br) begin
                    modelPc   = brTarget;
                    haveDel   = 1'b0;
                    expHalted = 1'b0;
                    if (prevReq) inflightDiscard = !ack;
                end else begin
                    if (prevValid && ready) begin
                        xferCount++;
                        delPc.push_back(prevPcO);
                        delInstr.push_back(prevInstrO);
                        haveDel = 1'b0;
                        if (expInstr[31:28] == 4'hF) expHalted = 1'b1;
                    end
                    if (prevReq && ack) begin
                        if (inflightDiscard) begin
                            inflightDiscard = 1'b0;
                        end else begin
                            haveDel  = 1'b1;
                            expPc    = reqAddrM;
                            expInstr = mem[reqAddrM];
                            modelPc  = reqAddrM + 12'd1;
                        end
                    end
                end
                chk("valid", 32'(valid), 32'(haveDel));
                if (haveDel) begin
                    chk("instr", instr, expInstr);
                    chk("pc", 32'(pc), 32'(expPc));
                end
                chk("halted", 32'(halted), 32'(expHalted));
                if (prevReq && !ack) begin
                    chk("req_hold", 32'(req), 32'h1);
                    chk("addr_hold", 32'(addr), 32'(reqAddrM));
                end
                if (req && !prevReq) begin
                    reqCount++;
                    chk("req_addr", 32'(addr), 32'(modelPc));
                    reqAddrM = addr;
                end
                if (req) chk("req_while_busy", 32'({valid, halted}), 32'h0);
                prevReq = req; prevValid = valid; prevPcO = pc; prevInstrO = instr;
            end
        end
    end

    // log the first requests and deliveries of the wrap-around instance
    logic        prevReq2 = 1'b0;
    logic [11:0] reqLog2[$];
    logic [11:0] delPc2[$];
    logic [31:0] delInstr2[$];
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (req2 && !prevReq2 && reqLog2.size() < 2) reqLog2.push_back(addr2);
                if (valid2 && delPc2.size() < 2) begin
                    delPc2.push_back(pc2);
                    delInstr2.push_back(instr2);
                end
            end
            prevReq2 = rst_n && req2;
        end
    end

    task automatic waitReq(input string name, input int n);
        for (int i = 0; i < 100 && reqCount == n; i++) @(negedge clk);
        chk(name, 32'(reqCount != n), 32'h1);
    endtask

    task automatic waitValid(input string name);
        for (int i = 0; i < 100 && !valid; i++) @(negedge clk);
        chk(name, 32'(valid), 32'h1);
    endtask

    int n, nx;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_addr", 32'(addr), 32'h000);
        chk("reset_instr", instr, 32'h0);
        chk("reset_req", 32'(req), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 100 && xferCount < 3; i++) @(negedge clk);
        chk("three_fetches_done", 32'(xferCount), 32'd3);
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("seq_pc", 32'(delPc[k]), 32'(k));
            chk("seq_instr", delInstr[k], 32'h1000_0000 + 32'(k));
        end

        waitValid("hlt_valid");
        repeat (5) begin
            @(negedge clk);
            chk("stall_instr", instr, 32'hF000_0000);
            chk("stall_pc", 32'(pc), 32'h003);
            chk("stall_req", 32'(req), 32'h0);
            chk("stall_valid", 32'(valid), 32'h1);
        end
        ready = 1'b1;
        @(negedge clk);
        chk("halt_set", 32'(halted), 32'h1);
        chk("halt_valid", 32'(valid), 32'h0);
        repeat (4) begin
            @(negedge clk);
            chk("halt_noreq", 32'(req), 32'h0);
        end

        n = reqCount;
        brTarget = 12'h010; br = 1'b1;
        @(negedge clk);
        br = 1'b0;
        chk("halt_cleared", 32'(halted), 32'h0);
        waitReq("req_after_halt_seen", n);
        chk("req_after_halt", 32'(addr), 32'h010);
        ackDelay = 4;

        n = reqCount;
        waitReq("req_011_seen", n);
        chk("req_011", 32'(addr), 32'h011);
        nx = xferCount;
        n = reqCount;
        brTarget = 12'h080; br = 1'b1;
        @(negedge clk);
        br = 1'b0;
        waitReq("req_redirect_seen", n);
        chk("req_redirect", 32'(addr), 32'h080);
        chk("discarded_no_xfer", 32'(xferCount), 32'(nx));
        ackDelay = 2;

        ready = 1'b0;
        waitValid("hold_valid");
        chk("hold_pc", 32'(pc), 32'h080);
        chk("hold_instr", instr, 32'h1000_0080);
        nx = xferCount;
        n = reqCount;
        brTarget = 12'h020; br = 1'b1; ready = 1'b1;
        @(negedge clk);
        br = 1'b0;
        chk("hold_drop_valid", 32'(valid), 32'h0);
        chk("hold_drop_xfer", 32'(xferCount), 32'(nx));
        waitReq("req_020_seen", n);
        chk("req_020", 32'(addr), 32'h020);

        chk("mid_req_high", 32'(req), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_req", 32'(req), 32'h0);
        chk("async_addr", 32'(addr), 32'h000);
        chk("async_instr", instr, 32'h0);
        chk("async_pc", 32'(pc), 32'h000);
        chk("async_valid", 32'(valid), 32'h0);
        chk("async_halted", 32'(halted), 32'h0);
        repeat (2) @(negedge clk);
        n = reqCount;
        rst_n = 1'b1;
        waitReq("refetch_seen", n);
        chk("refetch_addr", 32'(addr), 32'h000);
        waitValid("refetch_valid");
        chk("refetch_pc", 32'(pc), 32'h000);
        chk("refetch_instr", instr, 32'h1000_0000);

        chk("wrap_req_count", 32'(reqLog2.size()), 32'd2);
        chk("wrap_del_count", 32'(delPc2.size()), 32'd2);
        if (reqLog2.size() == 2 && delPc2.size() == 2) begin
            chk("wrap_req0", 32'(reqLog2[0]), 32'hFFF);
            chk("wrap_req1", 32'(reqLog2[1]), 32'h000);
            chk("wrap_pc0", 32'(delPc2[0]), 32'hFFF);
            chk("wrap_pc1", 32'(delPc2[1]), 32'h000);
            chk("wrap_instr0", delInstr2[0], 32'h1000_0FFF);
            chk("wrap_instr1", delInstr2[1], 32'h1000_0000);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
